uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two requesters: port 0 (monitor) and port 1 (cpu).
- Each requester pushes bytes into its own small FIFO.
- A round-robin scheduler drains the FIFOs into the UART one byte at a time, gated on the UART's is_transmitting.
- Sits between the monitor/cpu tx signals and the uart's transmit/tx_byte inputs, replacing the static monitor_control mux on the tx path.

---
 rtl/uart_tx_arbiter_pkg.sv | 11 +
 rtl/byte_fifo.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM state encodings and requester indices for the UART tx arbiter
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;
  localparam logic REQ_MON = 1'b0;
  localparam logic REQ_CPU = 1'b1;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: single-clock FIFO; a pop frees the slot so a push while full is accepted in the same cycle
module byte_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] count;
  logic do_push, do_pop;
  assign full    = count[DEPTH_LOG2];
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(do_push);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
      count  <= count + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART tx between monitor and cpu FIFOs; UART_TX_ARBITER_DROPCNT_EN adds drop_count
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int START_TMO  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_transmit,
  input  logic [7:0]  req0_byte,
  output logic        req0_full,
  input  logic        req1_transmit,
  input  logic [7:0]  req1_byte,
  output logic        req1_full,
  input  logic        is_transmitting,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        grant
`ifdef UART_TX_ARBITER_DROPCNT_EN
  ,
  output logic [15:0] drop_count
`endif
);
  localparam int TW = $clog2(START_TMO + 1);
  state_t state, state_n;
  logic [TW-1:0] tmo, tmo_n;
  logic empty0, empty1, pop0, pop1, sel, go;
  logic [7:0] dout0, dout1;

  byte_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo0 (
    .clk(clk), .rst(rst), .push(req0_transmit), .din(req0_byte), .pop(pop0),
    .full(req0_full), .empty(empty0), .dout(dout0)
  );

  byte_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo1 (
    .clk(clk), .rst(rst), .push(req1_transmit), .din(req1_byte), .pop(pop1),
    .full(req1_full), .empty(empty1), .dout(dout1)
  );

  assign transmit = state == ISSUE;
  assign busy     = !empty0 || !empty1 || state != IDLE;
  assign pop0     = go && sel == REQ_MON;
  assign pop1     = go && sel == REQ_CPU;

  // With both ports pending the one not served last wins; otherwise the only pending one.
  always_comb begin
    state_n = state;
    tmo_n   = tmo;
    go      = 1'b0;
    sel     = (!empty0 && !empty1) ? ~grant : (empty0 ? REQ_CPU : REQ_MON);
    case (state)
      IDLE:
        if ((!empty0 || !empty1) && !is_transmitting) begin
          go      = 1'b1;
          state_n = ISSUE;
        end
      ISSUE: begin
        state_n = WAIT_START;
        tmo_n   = '0;
      end
      WAIT_START:
        if (is_transmitting) state_n = WAIT_DONE;
        else begin
          tmo_n   = tmo + 1'b1;
          state_n = (tmo_n == TW'(START_TMO)) ? IDLE : WAIT_START;
        end
      WAIT_DONE:
        state_n = is_transmitting ? WAIT_DONE : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tmo     <= '0;
      tx_byte <= '0;
      grant   <= REQ_CPU;
    end else begin
      state <= state_n;
      tmo   <= tmo_n;
      if (go) begin
        tx_byte <= sel ? dout1 : dout0;
        grant   <= sel;
      end
    end
  end

`ifdef UART_TX_ARBITER_DROPCNT_EN
  logic [7:0] drop0, drop1;
  assign drop_count = {drop1, drop0};
  // A push is lost only when full and not relieved by a same-cycle pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop0 <= '0;
      drop1 <= '0;
    end else begin
      if (req0_transmit && req0_full && !pop0 && drop0 != 8'hFF) drop0 <= drop0 + 1'b1;
      if (req1_transmit && req1_full && !pop1 && drop1 != 8'hFF) drop1 <= drop1 + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of the UART tx arbiter against a queue-level model
module tb_uart_tx_arbiter;
  localparam int DEPTH_LOG2 = 2;
  localparam int START_TMO  = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0, rst = 1'b0;
  logic req0_transmit = 1'b0, req1_transmit = 1'b0;
  logic [7:0] req0_byte = '0, req1_byte = '0;
  logic req0_full, req1_full, transmit, busy, grant, is_transmitting;
  logic [7:0] tx_byte;
`ifdef UART_TX_ARBITER_DROPCNT_EN
  logic [15:0] drop_count;
`endif
  logic uart_busy = 1'b0, hold = 1'b0, uart_en = 1'b1;
  int uart_len = 10, left = 0, cyc = 0, last_busy = 0, viol = 0;
  int checks = 0, passes = 0, fails = 0;
  logic [7:0] rx_q[$];
  logic rg_q[$];
  int pc_q[$];

  assign is_transmitting = uart_busy | hold;

  uart_tx_arbiter #(.DEPTH_LOG2(DEPTH_LOG2), .START_TMO(START_TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_transmit(req0_transmit), .req0_byte(req0_byte), .req0_full(req0_full),
    .req1_transmit(req1_transmit), .req1_byte(req1_byte), .req1_full(req1_full),
    .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte),
    .busy(busy), .grant(grant)
`ifdef UART_TX_ARBITER_DROPCNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: logs each pulse, then stays busy for uart_len cycles starting the next cycle.
  initial forever begin
    @(posedge clk);
    #1;
    uart_busy = left > 0;
    if (left > 0) begin
      left--;
      last_busy = cyc;
    end
    if (transmit === 1'b1) begin
      if (uart_busy || hold) viol++;
      rx_q.push_back(tx_byte);
      rg_q.push_back(grant);
      pc_q.push_back(cyc);
      if (uart_en) left = uart_len;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic p0, input logic [7:0] b0, input logic p1, input logic [7:0] b1);
    req0_transmit = p0;
    req0_byte     = b0;
    req1_transmit = p1;
    req1_byte     = b1;
    @(negedge clk);
    req0_transmit = 1'b0;
    req1_transmit = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 300 && rx_q.size() < n; i++) @(negedge clk);
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    check("idle", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_log();
    rx_q.delete();
    rg_q.delete();
    pc_q.delete();
  endtask

  initial begin
    logic p0, p1, gm, s;
    logic [7:0] b0, b1;
    logic [7:0] m0[$], m1[$], exp_b[$];
    logic exp_g[$];
    logic [7:0] t3b[4];
    int n, k, d0, d1;

    // Reset held two edges while port 0 tries to push
    req0_transmit = 1'b1;
    req0_byte     = 8'h99;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req0_transmit = 1'b0;
    check("rst_transmit", transmit, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_grant", grant, 1'b1);
    check("rst_full0", req0_full, 1'b0);
    check("rst_full1", req1_full, 1'b0);
`ifdef UART_TX_ARBITER_DROPCNT_EN
    check("rst_drops", drop_count, 16'h0000);
`endif
    repeat (4) @(negedge clk);
    check("rst_no_push_busy", busy, 1'b0);
    check("rst_no_push_tx", rx_q.size(), 0);

    // Single byte latency and busy release
    uart_en  = 1'b1;
    uart_len = 10;
    k = cyc;
    push(1'b1, 8'h41, 1'b0, 8'h00);
    wait_rx(1);
    check("t2_byte", rx_q[0], 8'h41);
    check("t2_latency", pc_q[0] - k, 2);
    while (cyc < pc_q[0] + 11) @(negedge clk);
    check("t2_busy_at_fall", busy, 1'b1);
    @(negedge clk);
    check("t2_busy_after_fall", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("t2_single_pulse", rx_q.size(), 1);

    // Simultaneous pushes alternate starting with port 0 after reset
    do_reset();
    clear_log();
    t3b = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    push(1'b1, 8'hA0, 1'b1, 8'hB0);
    push(1'b1, 8'hA1, 1'b1, 8'hB1);
    wait_rx(4);
    for (int i = 0; i < 4; i++) begin
      check("t3_byte", rx_q[i], t3b[i]);
      check("t3_grant", rg_q[i], i[0]);
    end
    wait_idle();

    // Fill port 1 while the UART is held busy; overflow is dropped
    clear_log();
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(1'b0, 8'h00, 1'b1, 8'h10 + 8'(i));
      if (i == 2) check("t4_not_full", req1_full, 1'b0);
      if (i == 3) check("t4_full", req1_full, 1'b1);
    end
    check("t4_still_full", req1_full, 1'b1);
    check("t4_held", rx_q.size(), 0);
`ifdef UART_TX_ARBITER_DROPCNT_EN
    check("t4_drop1", drop_count[15:8], 8'd2);
    check("t4_drop0", drop_count[7:0], 8'd0);
`endif
    hold = 1'b0;
    wait_rx(4);
    for (int i = 0; i < 4; i++) begin
      check("t4_byte", rx_q[i], 8'h10 + 8'(i));
      check("t4_grant", rg_q[i], 1'b1);
    end
    wait_idle();
    check("t4_no_extra", rx_q.size(), 4);

    // UART never answers: each byte falls through after the start timeout
    clear_log();
    uart_en = 1'b0;
    push(1'b1, 8'h55, 1'b0, 8'h00);
    push(1'b1, 8'h66, 1'b0, 8'h00);
    wait_rx(2);
    check("t5_byte0", rx_q[0], 8'h55);
    check("t5_byte1", rx_q[1], 8'h66);
    check("t5_spacing", pc_q[1] - pc_q[0], START_TMO + 2);
    wait_idle();
    uart_en = 1'b1;

    // Reset during WAIT_DONE discards the queue; next byte waits for the UART
    clear_log();
    uart_len = 10;
    for (int i = 0; i < 4; i++) push(1'b1, 8'hC0 + 8'(i), 1'b0, 8'h00);
    wait_rx(1);
    while (cyc < pc_q[0] + 4) @(negedge clk);
    do_reset();
    check("t6_busy", busy, 1'b0);
    check("t6_transmit", transmit, 1'b0);
    check("t6_tx_byte", tx_byte, 8'h00);
    check("t6_grant", grant, 1'b1);
    push(1'b1, 8'h77, 1'b0, 8'h00);
    wait_rx(2);
    check("t6_byte", rx_q[1], 8'h77);
    check("t6_after_fall", pc_q[1], last_busy + 2);
    wait_idle();
    check("t6_no_stale", rx_q.size(), 2);

    // Randomized bursts against the queue model, UART held busy while loading
    do_reset();
    gm = 1'b1;
    d0 = 0;
    d1 = 0;
    for (int r = 0; r < 8; r++) begin
      clear_log();
      uart_len = int'($urandom_range(1, 5));
      hold = 1'b1;
      n = int'($urandom_range(2, 10));
      for (int i = 0; i < n; i++) begin
        p0 = 1'($urandom_range(0, 1));
        p1 = 1'($urandom_range(0, 1));
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        if (p0) begin
          if (m0.size() < DEPTH) m0.push_back(b0);
          else if (d0 < 255) d0++;
        end
        if (p1) begin
          if (m1.size() < DEPTH) m1.push_back(b1);
          else if (d1 < 255) d1++;
        end
        push(p0, b0, p1, b1);
      end
      check("rnd_full0", req0_full, m0.size() == DEPTH);
      check("rnd_full1", req1_full, m1.size() == DEPTH);
`ifdef UART_TX_ARBITER_DROPCNT_EN
      check("rnd_drops", drop_count, {8'(d1), 8'(d0)});
`endif
      exp_b.delete();
      exp_g.delete();
      while (m0.size() > 0 || m1.size() > 0) begin
        s = (m0.size() > 0 && m1.size() > 0) ? !gm : (m0.size() == 0);
        exp_b.push_back(s ? m1.pop_front() : m0.pop_front());
        exp_g.push_back(s);
        gm = s;
      end
      hold = 1'b0;
      wait_rx(exp_b.size());
      foreach (exp_b[i]) begin
        check("rnd_byte", rx_q[i], exp_b[i]);
        check("rnd_grant", rg_q[i], exp_g[i]);
      end
      wait_idle();
    end

    check("no_tx_while_busy", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
